// File: rtl/aes_arbiter.sv
// aes_arbiter: round-robin arbiter that shares one AES core between two
// requesters.
//   i_Clk, i_Rst (async, active low)
//   i_ReqN / i_EncN / i_TextN / i_KeyN : job request + operands per requester
//   o_AckN       : one-cycle pulse, job accepted (START cycle)
//   o_ValidN     : one-cycle pulse, o_DataN holds a new result (RESP cycle)
//   o_DataN      : last result for requester N, held until overwritten
//   o_Timeout    : one-cycle pulse, job aborted by the watchdog
//   o_Busy       : high whenever the FSM is not IDLE
//   o_AesStart/o_AesEnc/o_AesText/o_AesKey : request side of the AES core
//   i_AesData/i_AesDone                   : response side of the AES core
// Every output is a flop loaded from the next-state values.
module aes_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Req0,
  input  logic         i_Req1,
  input  logic         i_Enc0,
  input  logic         i_Enc1,
  input  logic [127:0] i_Text0,
  input  logic [127:0] i_Text1,
  input  logic [127:0] i_Key0,
  input  logic [127:0] i_Key1,
  output logic         o_Ack0,
  output logic         o_Ack1,
  output logic         o_Valid0,
  output logic         o_Valid1,
  output logic [127:0] o_Data0,
  output logic [127:0] o_Data1,
  output logic         o_Timeout,
  output logic         o_Busy,
  output logic         o_AesStart,
  output logic         o_AesEnc,
  output logic [127:0] o_AesText,
  output logic [127:0] o_AesKey,
  input  logic [127:0] i_AesData,
  input  logic         i_AesDone
);
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         hit_q, hit_d;
  logic         last_q, last_d;
  logic         gnt_q, gnt_d;
  logic         hold_enc_q, hold_enc_d;
  logic [127:0] hold_text_q, hold_text_d;
  logic [127:0] hold_key_q, hold_key_d;
  logic         abort;
  logic         drv;

  logic         ack0_q, ack0_d, ack1_q, ack1_d;
  logic         vld0_q, vld0_d, vld1_q, vld1_d;
  logic [127:0] data0_q, data0_d, data1_q, data1_d;
  logic         tmo_q, tmo_d, busy_q, busy_d, start_q, start_d;
  logic         aenc_q, aenc_d;
  logic [127:0] atext_q, atext_d, akey_q, akey_d;

  // State register plus all datapath and output flops.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      last_q      <= 1'b1;  // requester 0 wins the first tie
      gnt_q       <= 1'b0;
      hold_enc_q  <= 1'b0;
      hold_text_q <= '0;
      hold_key_q  <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      vld0_q      <= 1'b0;
      vld1_q      <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      aenc_q      <= 1'b0;
      atext_q     <= '0;
      akey_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      hold_enc_q  <= hold_enc_d;
      hold_text_q <= hold_text_d;
      hold_key_q  <= hold_key_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      vld0_q      <= vld0_d;
      vld1_q      <= vld1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      aenc_q      <= aenc_d;
      atext_q     <= atext_d;
      akey_q      <= akey_d;
    end
  end

  // Next state. The counter compare is registered (hit_q), so the abort
  // decision lands one cycle after the counter reads TIMEOUT-1; a done in
  // that same cycle still takes priority.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_d       = 1'b0;
    last_d      = last_q;
    gnt_d       = gnt_q;
    hold_enc_d  = hold_enc_q;
    hold_text_d = hold_text_q;
    hold_key_d  = hold_key_q;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Req0 || i_Req1) begin
          gnt_d       = (i_Req0 && i_Req1) ? ~last_q : i_Req1;
          last_d      = gnt_d;
          hold_enc_d  = gnt_d ? i_Enc1  : i_Enc0;
          hold_text_d = gnt_d ? i_Text1 : i_Text0;
          hold_key_d  = gnt_d ? i_Key1  : i_Key0;
          state_d     = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 6'd1;
        hit_d = (cnt_q == CNT_LAST);
        if (i_AesDone) begin
          state_d = RESP;
        end else if (hit_q) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values, decoded from the next state.
  always_comb begin
    drv     = (state_d == START) || (state_d == WAIT);
    ack0_d  = (state_d == START) && !gnt_d;
    ack1_d  = (state_d == START) &&  gnt_d;
    vld0_d  = (state_d == RESP)  && !gnt_d;
    vld1_d  = (state_d == RESP)  &&  gnt_d;
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    tmo_d   = abort;
    aenc_d  = drv && hold_enc_d;
    atext_d = drv ? hold_text_d : '0;
    akey_d  = drv ? hold_key_d  : '0;
    data0_d = data0_q;
    data1_d = data1_q;
    // Core done is only honoured while waiting on it.
    if (state_q == WAIT && i_AesDone) begin
      if (gnt_q) data1_d = i_AesData;
      else       data0_d = i_AesData;
    end
  end

  assign o_Ack0     = ack0_q;
  assign o_Ack1     = ack1_q;
  assign o_Valid0   = vld0_q;
  assign o_Valid1   = vld1_q;
  assign o_Data0    = data0_q;
  assign o_Data1    = data1_q;
  assign o_Timeout  = tmo_q;
  assign o_Busy     = busy_q;
  assign o_AesStart = start_q;
  assign o_AesEnc   = aenc_q;
  assign o_AesText  = atext_q;
  assign o_AesKey   = akey_q;

endmodule

// File: tb/tb_aes_arbiter.sv
module tb_aes_arbiter;
  localparam int TMO = 40;

  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] X0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] X1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] R3 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R4 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] R5 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] R6 = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] R7 = 128'h7b0c785e27e8ad3f8223207104725dd4;
  localparam logic [127:0] R8 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] R9 = 128'hcafef00d5555aaaa1234567887654321;

  logic clk, rst;
  logic req0, req1, enc0, enc1;
  logic [127:0] text0, text1, key0, key1;
  logic ack0, ack1, val0, val1, tmo, busy, astart, aenc;
  logic [127:0] data0, data1, atext, akey, aes_data;
  logic aes_done;

  int n_cmp = 0;
  int n_bad = 0;

  aes_arbiter #(.TIMEOUT(TMO)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Req0(req0), .i_Req1(req1), .i_Enc0(enc0), .i_Enc1(enc1),
    .i_Text0(text0), .i_Text1(text1), .i_Key0(key0), .i_Key1(key1),
    .o_Ack0(ack0), .o_Ack1(ack1), .o_Valid0(val0), .o_Valid1(val1),
    .o_Data0(data0), .o_Data1(data1), .o_Timeout(tmo), .o_Busy(busy),
    .o_AesStart(astart), .o_AesEnc(aenc), .o_AesText(atext), .o_AesKey(akey),
    .i_AesData(aes_data), .i_AesDone(aes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r0, r1, e0, e1;
    logic [127:0] t0, k0, t1, k1;
    int dly;             // WAIT cycle carrying done, 0 = core never answers
    logic [127:0] res;
    int g;
    logic [127:0] d0, d1;
  } vec_t;

  function automatic vec_t mk(logic r0, logic r1, logic e0, logic e1,
                              logic [127:0] t0, logic [127:0] k0,
                              logic [127:0] t1, logic [127:0] k1, int dly,
                              logic [127:0] res, int g,
                              logic [127:0] d0, logic [127:0] d1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
    v.t0 = t0; v.k0 = k0; v.t1 = t1; v.k1 = k1;
    v.dly = dly; v.res = res; v.g = g; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // {ack0, ack1, valid0, valid1, timeout, busy, aes_start, aes_enc}
  function automatic logic [7:0] flags();
    return {ack0, ack1, val0, val1, tmo, busy, astart, aenc};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; aes_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int   last;
    logic g;
    logic e;
    g = (v.g != 0);
    e = g ? v.e1 : v.e0;
    req0 = v.r0; req1 = v.r1; enc0 = v.e0; enc1 = v.e1;
    text0 = v.t0; key0 = v.k0; text1 = v.t1; key1 = v.k1;
    aes_done = 1'b0;
    tick();
    chk($sformatf("row%0d_start", idx), flags(), {!g, g, 5'b00011, e});
    chk($sformatf("row%0d_text", idx), atext, g ? v.t1 : v.t0);
    chk($sformatf("row%0d_key", idx), akey, g ? v.k1 : v.k0);
    // operands must have been captured: scramble the live inputs
    req0 = 1'b0; req1 = 1'b0;
    text0 = r128(); text1 = r128(); key0 = r128(); key1 = r128();
    enc0 = ~enc0; enc1 = ~enc1;
    last = (v.dly != 0) ? v.dly : TMO + 1;
    for (int k = 1; k <= last; k++) begin
      tick();
      chk($sformatf("row%0d_wait%0d", idx, k), flags(), {5'b00000, 2'b10, e});
      chk($sformatf("row%0d_wtext%0d", idx, k), atext, g ? v.t1 : v.t0);
      aes_done = (k == v.dly);
      aes_data = (k == v.dly) ? v.res : r128();
    end
    tick();
    aes_done = 1'b0;
    if (v.dly != 0) begin
      chk($sformatf("row%0d_resp", idx), flags(), {2'b00, !g, g, 4'b0100});
    end else begin
      chk($sformatf("row%0d_timeout", idx), flags(), 8'b0000_1000);
    end
    chk($sformatf("row%0d_data0", idx), data0, v.d0);
    chk($sformatf("row%0d_data1", idx), data1, v.d1);
    if (v.dly != 0) begin
      tick();
      chk($sformatf("row%0d_idle", idx), flags(), 8'h00);
    end
  endtask

  vec_t tbl[9];

  initial begin
    logic g;
    logic [127:0] ed0, ed1, rr;
    // random-phase model state: one job at a time, described by its cycle numbers
    bit jact, jdone, rr_last, pend0, pend1;
    bit e_start, e_val, e_to, e_busy, e_drv, in_wait;
    int js, je, jfree, jg, dly, sel;
    logic jenc;
    logic [127:0] jtext, jkey, jres, md0, md1;

    tbl[0] = mk(1, 0, 1, 0, P,  K,  '0, '0, 5,       C,  0, C,  '0);
    tbl[1] = mk(0, 1, 0, 0, '0, '0, C,  K,  10,      P,  1, C,  P);
    tbl[2] = mk(1, 1, 1, 0, X0, K,  X1, K2, 3,       R3, 0, R3, P);
    tbl[3] = mk(1, 1, 0, 1, X0, K2, X1, K,  TMO,     R4, 1, R3, R4);
    tbl[4] = mk(1, 1, 1, 1, X1, K,  X0, K2, TMO + 1, R5, 0, R5, R4);
    tbl[5] = mk(0, 1, 0, 1, '0, '0, X0, K,  0,       R6, 1, R5, R4);
    tbl[6] = mk(1, 1, 0, 0, X1, K2, X0, K,  1,       R7, 0, R7, R4);
    tbl[7] = mk(1, 0, 1, 0, X0, K,  '0, '0, 2,       R8, 0, R8, R4);
    tbl[8] = mk(1, 1, 1, 0, X0, K2, X1, K,  4,       R9, 1, R8, R9);

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; enc0 = 1'b0; enc1 = 1'b0;
    text0 = '0; text1 = '0; key0 = '0; key1 = '0;
    aes_done = 1'b0; aes_data = '0;

    // reset state
    do_reset();
    chk("reset_flags", flags(), 8'h00);
    chk("reset_data0", data0, '0);
    chk("reset_data1", data1, '0);
    chk("reset_aes", {atext, akey} == '0, 1'b1);

    // both requests held from reset: grants alternate 0,1,0,1
    text0 = X0; key0 = K; enc0 = 1'b1; text1 = X1; key1 = K2; enc1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1; ed0 = '0; ed1 = '0;
    for (int j = 0; j < 4; j++) begin
      g = j[0];
      tick();
      chk($sformatf("alt%0d_ack", j), {ack0, ack1}, {!g, g});
      chk($sformatf("alt%0d_text", j), atext, g ? X1 : X0);
      tick(); tick();
      rr = r128();
      aes_done = 1'b1; aes_data = rr;
      tick();
      aes_done = 1'b0;
      if (g) ed1 = rr; else ed0 = rr;
      chk($sformatf("alt%0d_valid", j), {val0, val1}, {!g, g});
      chk($sformatf("alt%0d_data0", j), data0, ed0);
      chk($sformatf("alt%0d_data1", j), data1, ed1);
      tick();
      chk($sformatf("alt%0d_idle", j), busy, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // single-job vectors
    do_reset();
    for (int i = 0; i < 9; i++) run_row(tbl[i], i);

    // spurious done while idle
    aes_done = 1'b1; aes_data = r128();
    tick();
    aes_done = 1'b0;
    chk("spur_flags", flags(), 8'h00);
    chk("spur_data0", data0, R8);
    chk("spur_data1", data1, R9);
    tick();
    chk("spur_flags2", flags(), 8'h00);

    // reset in the middle of WAIT
    req0 = 1'b1; text0 = X1; key0 = K; enc0 = 1'b1;
    tick();
    chk("rstw_ack", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk("rstw_flags", flags(), 8'h00);
    chk("rstw_aes", {atext, akey} == '0, 1'b1);
    chk("rstw_data", {data0, data1} == '0, 1'b1);
    @(negedge clk) rst = 1'b1;
    tick();
    aes_done = 1'b1; aes_data = r128();
    tick();
    aes_done = 1'b0;
    chk("rstw_late_done", flags(), 8'h00);
    chk("rstw_late_data", {data0, data1} == '0, 1'b1);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rstw_tie", {ack0, ack1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;

    // randomized traffic against the job-timeline model
    do_reset();
    jact = 0; jdone = 0; rr_last = 1; pend0 = 0; pend1 = 0;
    js = 0; je = 0; jfree = 0; jg = 0; jenc = 0;
    jtext = '0; jkey = '0; jres = '0; md0 = '0; md1 = '0;
    for (int c = 0; c < 3000; c++) begin
      // a job: START at js, WAIT js+1..je, then RESP at je+1 or abort
      e_start = jact && c == js;
      e_drv   = jact && c >= js && c <= je;
      e_busy  = jact && c >= js && c < jfree;
      e_val   = jact && jdone && c == je + 1;
      e_to    = jact && !jdone && c == je + 1;
      if (e_val) begin
        if (jg != 0) md1 = jres; else md0 = jres;
      end
      chk($sformatf("rnd%0d_flags", c), flags(),
          {e_start && jg == 0, e_start && jg != 0, e_val && jg == 0, e_val && jg != 0,
           e_to, e_busy, e_start, e_drv && jenc});
      chk($sformatf("rnd%0d_aes", c), {atext, akey}, e_drv ? {jtext, jkey} : 256'd0);
      chk($sformatf("rnd%0d_data0", c), data0, md0);
      chk($sformatf("rnd%0d_data1", c), data1, md1);

      // requesters: drop in the ack cycle, new jobs arrive at random
      if (e_start) begin
        if (jg != 0) pend1 = 0; else pend0 = 0;
      end
      if (!pend0 && !(e_start && jg == 0) && $urandom_range(0, 3) == 0) begin
        pend0 = 1; enc0 = 1'($urandom); text0 = r128(); key0 = r128();
      end
      if (!pend1 && !(e_start && jg != 0) && $urandom_range(0, 3) == 0) begin
        pend1 = 1; enc1 = 1'($urandom); text1 = r128(); key1 = r128();
      end
      req0 = pend0; req1 = pend1;

      // core: answers on schedule, otherwise random noise outside WAIT
      in_wait = jact && c > js && c <= je;
      if (jact && jdone && c == je) begin
        aes_done = 1'b1; aes_data = jres;
      end else begin
        aes_done = !in_wait && ($urandom_range(0, 5) == 0);
        aes_data = r128();
      end

      // grant decision when the arbiter is free this cycle
      if ((!jact || c >= jfree) && (req0 || req1)) begin
        jg = (req0 && req1) ? int'(!rr_last) : int'(req1);
        rr_last = (jg != 0);
        jenc  = (jg != 0) ? enc1  : enc0;
        jtext = (jg != 0) ? text1 : text0;
        jkey  = (jg != 0) ? key1  : key0;
        sel = $urandom_range(0, 9);
        if (sel == 0)      dly = 0;
        else if (sel == 1) dly = $urandom_range(TMO - 1, TMO + 1);
        else               dly = $urandom_range(1, 6);
        js    = c + 1;
        jdone = (dly != 0);
        je    = jdone ? js + dly : js + TMO + 1;
        jfree = jdone ? je + 2 : je + 1;
        jres  = r128();
        jact  = 1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
